// File: rtl/mole_if.sv
// mole_if: start/switch inputs and mole/score outputs
// between the board-side driver and mole_scheduler.
interface mole_if;
  logic        start;
  logic [17:0] hit_sw;
  logic [4:0]  mole_num;
  logic        mole_valid;
  logic [7:0]  score;
  logic [7:0]  misses;
  logic [7:0]  moles_done;
  logic        game_over;

  modport master (
    output start, hit_sw,
    input  mole_num, mole_valid, score,
    input  misses, moles_done, game_over
  );

  modport slave (
    input  start, hit_sw,
    output mole_num, mole_valid, score,
    output misses, moles_done, game_over
  );
endinterface

// File: rtl/mole_scheduler.sv
// mole_scheduler: LFSR-picked moles, up/gap timing, score and miss counting.
// Define MOLE_PENALTY_EN to make wrong-hole hits count as a miss.
module mole_scheduler #(
  parameter int         NUM_HOLES   = 18,
  parameter int         UP_CYCLES   = 50_000_000,
  parameter int         GAP_CYCLES  = 25_000_000,
  parameter int         ROUND_MOLES = 20,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input logic   clk,
  input logic   rst_n,
  mole_if.slave bus
);
  localparam logic [7:0]  SEED =
    (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [31:0] UP_LD  = 32'(UP_CYCLES - 1);
  localparam logic [31:0] GAP_LD = 32'(GAP_CYCLES - 1);
  localparam logic [7:0]  RM     = 8'(ROUND_MOLES);
  localparam logic [5:0]  NH     = 6'(NUM_HOLES);
  localparam logic [31:0] MASK   =
    32'((64'd1 << NUM_HOLES) - 64'd1);

  typedef enum logic [2:0] {
    IDLE, GAP, PICK, UP, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  lfsr;
  logic [17:0] sync1, sync2, prev;
  logic [31:0] timer, timer_d;
  logic [4:0]  num, num_d;
  logic [7:0]  score, score_d;
  logic [7:0]  misses, misses_d;
  logic [7:0]  done, done_d;
  logic [31:0] rise;
  logic        hit;
  logic        fin;
  logic [4:0]  cand;

  assign cand = lfsr[4:0];
  // Switches beyond the valid hole range never produce an edge.
  assign rise = {14'd0, sync2 & ~prev} & MASK;
  assign hit  = rise[num];

`ifdef MOLE_PENALTY_EN
  logic wrong;
  assign wrong = |(rise & ~(32'd1 << num));
`endif

  always_comb begin
    state_d  = state_q;
    timer_d  = timer;
    num_d    = num;
    score_d  = score;
    misses_d = misses;
    done_d   = done;
    fin      = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          score_d  = '0;
          misses_d = '0;
          done_d   = '0;
          timer_d  = GAP_LD;
          state_d  = GAP;
        end
      end
      GAP: begin
        if (timer == '0) state_d = PICK;
        else timer_d = timer - 32'd1;
      end
      PICK: begin
        if ({1'b0, cand} < NH) begin
          num_d   = cand;
          timer_d = UP_LD;
          state_d = UP;
        end
      end
      UP: begin
        if (hit) begin
          if (score != 8'hFF) score_d = score + 8'd1;
          fin = 1'b1;
`ifdef MOLE_PENALTY_EN
        end else if (wrong || timer == '0) begin
`else
        end else if (timer == '0) begin
`endif
          if (misses != 8'hFF) misses_d = misses + 8'd1;
          fin = 1'b1;
        end else begin
          timer_d = timer - 32'd1;
        end
        if (fin) begin
          num_d  = 5'd31;
          done_d = done + 8'd1;
          if (done + 8'd1 == RM) begin
            state_d = DONE;
          end else begin
            timer_d = GAP_LD;
            state_d = GAP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr    <= SEED;
      sync1   <= '0;
      sync2   <= '0;
      prev    <= '0;
      timer   <= '0;
      num     <= 5'd31;
      score   <= '0;
      misses  <= '0;
      done    <= '0;
    end else begin
      state_q <= state_d;
      // x^8+x^6+x^5+x^4+1, free-running in every state
      lfsr    <= {lfsr[6:0],
                  lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      sync1   <= bus.hit_sw;
      sync2   <= sync1;
      prev    <= sync2;
      timer   <= timer_d;
      num     <= num_d;
      score   <= score_d;
      misses  <= misses_d;
      done    <= done_d;
    end
  end

  assign bus.mole_num   = num;
  assign bus.mole_valid = (state_q == UP);
  assign bus.score      = score;
  assign bus.misses     = misses;
  assign bus.moles_done = done;
  assign bus.game_over  = (state_q == DONE);
endmodule

// File: tb/tb_mole_scheduler.sv
// tb_mole_scheduler: scoreboard bench for mole_scheduler
// with short up/gap windows and three-mole rounds.
module tb_mole_scheduler;
  localparam int UPC  = 8;
  localparam int GAPC = 4;
  localparam int RMC  = 3;
  localparam int NHC  = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mole_if bus();

  mole_scheduler #(
    .NUM_HOLES  (NHC),
    .UP_CYCLES  (UPC),
    .GAP_CYCLES (GAPC),
    .ROUND_MOLES(RMC),
    .LFSR_SEED  (8'hA5)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int len;
    int ds;
    int dm;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic check(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  // Mole monitor: measures each UP window and scores it
  initial begin
    logic pv;
    int len, s0, m0;
    exp_t e;
    pv = 1'b0;
    len = 0;
    s0 = 0;
    m0 = 0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        pv = 1'b0;
        len = 0;
      end else begin
        if (bus.mole_valid) begin
          if (!pv) begin
            len = 1;
            s0 = int'(bus.score);
            m0 = int'(bus.misses);
            check("mole_range",
                  int'(bus.mole_num < 5'(NHC)), 1);
          end else begin
            len++;
          end
        end else if (pv) begin
          if (sb.size() == 0) begin
            check("sb_empty", 0, 1);
          end else begin
            e = sb.pop_front();
            check("up_len", len, e.len);
            check("d_score", int'(bus.score) - s0, e.ds);
            check("d_miss", int'(bus.misses) - m0, e.dm);
          end
        end
        pv = bus.mole_valid;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_up(output logic [4:0] n);
    int cnt;
    bit ok;
    cnt = 1;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (bus.mole_valid) begin
        ok = 1'b1;
        break;
      end
      cnt++;
      @(negedge clk);
    end
    check("up_seen", int'(ok), 1);
    check("gap_min", int'(cnt >= GAPC + 1), 1);
    n = bus.mole_num;
  endtask

  task automatic wait_down();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.mole_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("down_seen", int'(ok), 1);
  endtask

  // mode 0: no switch, 1: correct hole at k, 2: wrong hole at k
  task automatic mole(int mode, int k, bit keep);
    logic [4:0] n;
    int w;
    wait_up(n);
    if (n >= 5'(NHC)) n = 5'd0;
    w = (int'(n) + 1) % NHC;
    case (mode)
      0: sb.push_back('{UPC, 0, 1});
      1: begin
        sb.push_back('{k + 3, 1, 0});
        repeat (k) @(negedge clk);
        bus.hit_sw[n] = 1'b1;
      end
      2: begin
`ifdef MOLE_PENALTY_EN
        sb.push_back('{k + 3, 0, 1});
`else
        sb.push_back('{UPC, 0, 1});
`endif
        repeat (k) @(negedge clk);
        bus.hit_sw[w] = 1'b1;
      end
      default: ;
    endcase
    wait_down();
    if (!keep) bus.hit_sw = '0;
  endtask

  task automatic check_end(string tag, int s, int m);
    check({tag, "_score"}, int'(bus.score), s);
    check({tag, "_miss"}, int'(bus.misses), m);
    check({tag, "_done"}, int'(bus.moles_done), RMC);
    check({tag, "_over"}, int'(bus.game_over), 1);
    check({tag, "_num"}, int'(bus.mole_num), 31);
  endtask

  initial begin
    logic [4:0] n;
    bus.start = 1'b0;
    bus.hit_sw = '0;
    repeat (3) @(negedge clk);
    check("rst_num", int'(bus.mole_num), 31);
    check("rst_valid", int'(bus.mole_valid), 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_num", int'(bus.mole_num), 31);
    check("idle_valid", int'(bus.mole_valid), 0);
    check("idle_score", int'(bus.score), 0);
    check("idle_miss", int'(bus.misses), 0);
    check("idle_done", int'(bus.moles_done), 0);
    check("idle_over", int'(bus.game_over), 0);

    pulse_start();
    repeat (RMC) mole(0, 0, 1'b0);
    check_end("rA", 0, 3);

    pulse_start();
    check("rB_clr_miss", int'(bus.misses), 0);
    check("rB_clr_over", int'(bus.game_over), 0);
    repeat (RMC) mole(1, 2, 1'b0);
    check_end("rB", 3, 0);

    pulse_start();
    mole(2, 2, 1'b0);
    mole(1, 5, 1'b1);
    mole(0, 0, 1'b0);
    check_end("rC", 1, 2);

    pulse_start();
    mole(1, 2, 1'b0);
    wait_up(n);
    check("rD_score", int'(bus.score), 1);
    repeat (2) @(negedge clk);
    sb.delete();
    rst_n = 1'b0;
    #1;
    check("mid_num", int'(bus.mole_num), 31);
    check("mid_valid", int'(bus.mole_valid), 0);
    check("mid_score", int'(bus.score), 0);
    check("mid_miss", int'(bus.misses), 0);
    check("mid_done", int'(bus.moles_done), 0);
    check("mid_over", int'(bus.game_over), 0);
    bus.hit_sw = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    repeat (RMC) mole(0, 0, 1'b0);
    check_end("rE", 0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
